// File: rtl/dma_loopback_sequencer_if.sv
// AXI-Lite bus between the loopback sequencer (master) and the DMA register port (slave).
interface dma_loopback_sequencer_if #(
   parameter int AXIL_ADDR_WIDTH = 40,
   parameter int AXIL_WIDTH      = 32
);
   logic [AXIL_ADDR_WIDTH-1:0] awaddr;
   logic [2:0]                 awprot;
   logic                       awvalid;
   logic                       awready;
   logic [AXIL_WIDTH-1:0]      wdata;
   logic [AXIL_WIDTH/8-1:0]    wstrb;
   logic                       wvalid;
   logic                       wready;
   logic [1:0]                 bresp;
   logic                       bvalid;
   logic                       bready;
   logic [AXIL_ADDR_WIDTH-1:0] araddr;
   logic [2:0]                 arprot;
   logic                       arvalid;
   logic                       arready;
   logic [AXIL_WIDTH-1:0]      rdata;
   logic [1:0]                 rresp;
   logic                       rvalid;
   logic                       rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/dma_loopback_sequencer.sv
// Programs the loopback DMA (S2MM first, then MM2S) over AXI-Lite and polls both DMASR.Idle bits.
// Optional macro POLL_TIMEOUT_EN: abort with err_code 3 after TIMEOUT_POLLS not-idle reads on one channel.
module dma_loopback_sequencer #(
   parameter int          AXIL_WIDTH      = 32,
   parameter int          AXIL_ADDR_WIDTH = 40,
   parameter int          AXI_ADDR_WIDTH  = 32,
   parameter int          LEN_WIDTH       = 26,
   parameter logic [31:0] AXIL_BASE_ADDR  = 32'h3000000,
   parameter int          POLL_GAP        = 16,
   parameter int          TIMEOUT_POLLS   = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [AXI_ADDR_WIDTH-1:0] src_addr,
   input  logic [AXI_ADDR_WIDTH-1:0] dst_addr,
   input  logic [LEN_WIDTH-1:0]      len_bytes,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [1:0]                err_code,
   dma_loopback_sequencer_if.master  m_axil
);
   localparam logic [AXIL_ADDR_WIDTH-1:0] BASE = AXIL_ADDR_WIDTH'(AXIL_BASE_ADDR);
   localparam int GW = $clog2(POLL_GAP + 1);

   typedef enum logic [3:0] {
      IDLE, WR, WRESP, POLL_MM2S, POLL_S2MM, RDATA, GAP, DONE, ERR
   } state_t;

   state_t                    state_q, state_d;
   logic [2:0]                step_q;
   logic                      chan_q;
   logic                      aw_done_q, w_done_q;
   logic [GW-1:0]             gap_q;
   logic [AXI_ADDR_WIDTH-1:0] src_q, dst_q;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [1:0]                err_code_q, err_d;
   logic [7:0]                wr_off;
   logic [AXIL_WIDTH-1:0]     wr_val;
   logic                      aw_hs, w_hs;
`ifdef POLL_TIMEOUT_EN
   localparam int PW = $clog2(TIMEOUT_POLLS + 1);
   logic [PW-1:0]             poll_q;
`else
   localparam int unused_timeout_polls = TIMEOUT_POLLS;
`endif

   // Only the Idle bit of DMASR matters here.
   logic unused_rdata;
   assign unused_rdata = ^{m_axil.rdata[AXIL_WIDTH-1:2], m_axil.rdata[0]};

   assign aw_hs    = m_axil.awvalid & m_axil.awready;
   assign w_hs     = m_axil.wvalid & m_axil.wready;
   assign err_code = err_code_q;

   always_comb begin
      state_d        = state_q;
      err_d          = 2'd0;
      wr_off         = 8'h00;
      wr_val         = '0;
      busy           = 1'b0;
      done           = 1'b0;
      error          = 1'b0;
      m_axil.awaddr  = '0;
      m_axil.awprot  = 3'd0;
      m_axil.awvalid = 1'b0;
      m_axil.wdata   = '0;
      m_axil.wstrb   = '1;
      m_axil.wvalid  = 1'b0;
      m_axil.bready  = 1'b0;
      m_axil.araddr  = '0;
      m_axil.arprot  = 3'd0;
      m_axil.arvalid = 1'b0;
      m_axil.rready  = 1'b0;

      // S2MM is armed before MM2S so looped-back data always has a destination.
      case (step_q)
         3'd0:    begin wr_off = 8'h30; wr_val = AXIL_WIDTH'(1);     end
         3'd1:    begin wr_off = 8'h48; wr_val = AXIL_WIDTH'(dst_q); end
         3'd2:    begin wr_off = 8'h58; wr_val = AXIL_WIDTH'(len_q); end
         3'd3:    begin wr_off = 8'h00; wr_val = AXIL_WIDTH'(1);     end
         3'd4:    begin wr_off = 8'h18; wr_val = AXIL_WIDTH'(src_q); end
         default: begin wr_off = 8'h28; wr_val = AXIL_WIDTH'(len_q); end
      endcase

      case (state_q)
         IDLE: if (start) state_d = WR;
         WR: begin
            busy           = 1'b1;
            m_axil.awvalid = ~aw_done_q;
            m_axil.wvalid  = ~w_done_q;
            m_axil.awaddr  = BASE + AXIL_ADDR_WIDTH'(wr_off);
            m_axil.wdata   = wr_val;
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WRESP;
         end
         WRESP: begin
            busy          = 1'b1;
            m_axil.bready = 1'b1;
            if (m_axil.bvalid) begin
               if (m_axil.bresp != 2'd0) begin
                  state_d = ERR;
                  err_d   = 2'd1;
               end else begin
                  state_d = (step_q == 3'd5) ? POLL_MM2S : WR;
               end
            end
         end
         POLL_MM2S, POLL_S2MM: begin
            busy           = 1'b1;
            m_axil.arvalid = 1'b1;
            m_axil.araddr  = BASE + ((state_q == POLL_S2MM) ? AXIL_ADDR_WIDTH'(8'h34)
                                                            : AXIL_ADDR_WIDTH'(8'h04));
            if (m_axil.arready) state_d = RDATA;
         end
         RDATA: begin
            busy          = 1'b1;
            m_axil.rready = 1'b1;
            if (m_axil.rvalid) begin
               if (m_axil.rresp != 2'd0) begin
                  state_d = ERR;
                  err_d   = 2'd2;
               end else if (m_axil.rdata[1]) begin
                  state_d = chan_q ? DONE : POLL_S2MM;
`ifdef POLL_TIMEOUT_EN
               end else if (poll_q == PW'(TIMEOUT_POLLS - 1)) begin
                  state_d = ERR;
                  err_d   = 2'd3;
`endif
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            busy = 1'b1;
            if (gap_q == '0) state_d = chan_q ? POLL_S2MM : POLL_MM2S;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         ERR: begin
            error   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         step_q     <= 3'd0;
         chan_q     <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         gap_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         err_code_q <= 2'd0;
`ifdef POLL_TIMEOUT_EN
         poll_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (start) begin
               src_q      <= src_addr;
               dst_q      <= dst_addr;
               len_q      <= len_bytes;
               step_q     <= 3'd0;
               err_code_q <= 2'd0;
            end
            WR: begin
               if (state_d == WRESP) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
               end else begin
                  aw_done_q <= aw_done_q | aw_hs;
                  w_done_q  <= w_done_q | w_hs;
               end
            end
            WRESP: if (m_axil.bvalid) step_q <= step_q + 3'd1;
            GAP:   if (gap_q != '0) gap_q <= gap_q - GW'(1);
            default: ;
         endcase
         if (state_d == GAP && state_q == RDATA) begin
            gap_q <= GW'(POLL_GAP - 1);
`ifdef POLL_TIMEOUT_EN
            poll_q <= poll_q + PW'(1);
`endif
         end
         // The poll counter restarts with each channel's poll phase.
         if (state_q == WRESP && state_d == POLL_MM2S) begin
            chan_q <= 1'b0;
`ifdef POLL_TIMEOUT_EN
            poll_q <= '0;
`endif
         end
         if (state_q == RDATA && state_d == POLL_S2MM) begin
            chan_q <= 1'b1;
`ifdef POLL_TIMEOUT_EN
            poll_q <= '0;
`endif
         end
         if (state_d == ERR) err_code_q <= err_d;
      end
   end
endmodule
